// File: rtl/booth_r4_pkg.sv
// Shared definitions for the radix-4 Booth MAC: digit codes, digit count, digit decode.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package booth_r4_pkg;

  // Radix-4 Booth digit codes, one per multiplier bit-triplet
  localparam logic [2:0] BOOTH_ZERO = 3'd0;
  localparam logic [2:0] BOOTH_POS1 = 3'd1;
  localparam logic [2:0] BOOTH_POS2 = 3'd2;
  localparam logic [2:0] BOOTH_NEG2 = 3'd3;
  localparam logic [2:0] BOOTH_NEG1 = 3'd4;

  // Digits needed to cover an N-bit operand extended to N+2 bits
  function automatic int num_pp(input int n);
    return n / 2 + 1;
  endfunction

  // Triplet is {b[2i+1], b[2i], b[2i-1]}
  function automatic logic [2:0] booth_decode(input logic [2:0] trip);
    logic [2:0] code;
    case (trip)
      3'b001, 3'b010: code = BOOTH_POS1;
      3'b011:         code = BOOTH_POS2;
      3'b100:         code = BOOTH_NEG2;
      3'b101, 3'b110: code = BOOTH_NEG1;
      default:        code = BOOTH_ZERO;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// One radix-4 Booth partial product: selects 0/+A/+2A/-A/-2A from a multiplier triplet.
// Latency: combinational.
// Backpressure: none (pure logic, held by the enclosing pipeline).
// Ports: a_ext   - multiplicand already extended to N+2 bits
//        triplet - multiplier bits {2i+1, 2i, 2i-1}
//        pp      - partial product sign-extended to 2N+2 bits, one's-complemented if negative
//        neg     - +1 correction owed at the partial product LSB
module booth_r4_pp_gen
  import booth_r4_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N+1:0]   a_ext,
  input  logic [2:0]     triplet,
  output logic [2*N+1:0] pp,
  output logic           neg
);

  logic [2:0]     digit;
  logic [2*N+1:0] a_sx;
  logic [2*N+1:0] a2_sx;

  always_comb begin
    digit = booth_decode(triplet);
    a_sx  = {{N{a_ext[N+1]}}, a_ext};
    // a_sx carries N copies of the sign, so dropping its MSB keeps 2A exact
    a2_sx = {a_sx[2*N:0], 1'b0};
    pp    = '0;
    neg   = 1'b0;
    case (digit)
      BOOTH_POS1: pp = a_sx;
      BOOTH_POS2: pp = a2_sx;
      BOOTH_NEG1: begin
        pp  = ~a_sx;
        neg = 1'b1;
      end
      BOOTH_NEG2: begin
        pp  = ~a2_sx;
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_r4_pipe_mac.sv
// Pipelined radix-4 Booth multiply-accumulate for the systolic PE datapath.
// Latency: 3 cycles from input handshake to out_valid; one beat per cycle at full throughput.
// Backpressure: whole pipe freezes while out_valid & !out_ready; in_ready mirrors that.
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_a/in_b/in_signed/in_acc_en/
//        in_acc_clr operand beat; out_valid/out_ready/out_data/out_ovf result beat.
module booth_r4_pipe_mac
  import booth_r4_pkg::*;
#(
  parameter int N     = 16,
  parameter int ACC_W = 2*N+8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_signed,
  input  logic             in_acc_en,
  input  logic             in_acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int NPP  = num_pp(N);
  localparam int W    = 2*N+2;
  localparam int ROWS = NPP + 1;   // partial products plus the negation-correction row

  if ((N % 2) != 0 || N < 4 || ACC_W < 2*N+2) begin : g_bad_params
    $error("booth_r4_pipe_mac: N must be even and >= 4, ACC_W must be >= 2*N+2");
  end

  logic advance;

  // S1 state
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         sgn1_q, sgn1_d, en1_q, en1_d, clr1_q, clr1_d, v1_q, v1_d;
  // S2 state
  logic [W-1:0] sum2_q, sum2_d, carry2_q, carry2_d;
  logic         sgn2_q, sgn2_d, en2_q, en2_d, clr2_q, clr2_d, v2_q, v2_d;
  // S3 state
  logic [ACC_W-1:0] out_data_q, out_data_d, acc_q, acc_d;
  logic             out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;

  // ---------------- S2 combinational: Booth encode + carry-save reduce ----------------
  logic [N+1:0] a_ext;
  logic [N+2:0] b_ext0;          // extended multiplier with the implicit 0 below its LSB
  logic [W-1:0] pp_arr [NPP];
  logic [NPP-1:0] neg_vec;
  logic [W-1:0] row [ROWS];

  always_comb begin
    a_ext  = {{2{sgn1_q & a_q[N-1]}}, a_q};
    b_ext0 = {{2{sgn1_q & b_q[N-1]}}, b_q, 1'b0};
  end

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_r4_pp_gen #(.N(N)) u_pp (
      .a_ext   (a_ext),
      .triplet (b_ext0[2*i+2:2*i]),
      .pp      (pp_arr[i]),
      .neg     (neg_vec[i])
    );
  end

  // Correction bits sit at distinct positions 2i, so they share a single row
  always_comb begin
    row[NPP] = '0;
    for (int i = 0; i < NPP; i++) begin
      row[i]   = pp_arr[i] << (2*i);
      row[NPP] = row[NPP] | (W'(neg_vec[i]) << (2*i));
    end
  end

  // Chain of 3:2 compressors; everything is mod 2^W, which holds the exact product
  logic [W-1:0] cs_s [ROWS-1];
  logic [W-1:0] cs_c [ROWS-1];

  assign cs_s[0] = row[0];
  assign cs_c[0] = row[1];

  for (genvar k = 2; k < ROWS; k++) begin : g_csa
    logic [W-1:0] maj;
    assign maj       = (cs_s[k-2] & cs_c[k-2]) | (cs_s[k-2] & row[k]) | (cs_c[k-2] & row[k]);
    assign cs_s[k-1] = cs_s[k-2] ^ cs_c[k-2] ^ row[k];
    assign cs_c[k-1] = maj << 1;
  end

  // ---------------- S3 combinational: CPA + accumulate ----------------
  logic [W-1:0]     prod_w;
  logic [ACC_W-1:0] prod_ext, acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             sgn_ovf;

  always_comb begin
    prod_w   = sum2_q + carry2_q;
    // The W-bit value is the exact two's-complement product in both modes
    prod_ext = ACC_W'($signed(prod_w));
    acc_base = clr2_q ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, prod_ext};
    sgn_ovf  = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (acc_sum[ACC_W-1] != acc_base[ACC_W-1]);
  end

  // ---------------- Next-state ----------------
  assign advance = !out_valid_q || out_ready;

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    sgn1_d      = sgn1_q;
    en1_d       = en1_q;
    clr1_d      = clr1_q;
    v1_d        = v1_q;
    sum2_d      = sum2_q;
    carry2_d    = carry2_q;
    sgn2_d      = sgn2_q;
    en2_d       = en2_q;
    clr2_d      = clr2_q;
    v2_d        = v2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    if (advance) begin
      a_d         = in_a;
      b_d         = in_b;
      sgn1_d      = in_signed;
      en1_d       = in_acc_en;
      clr1_d      = in_acc_clr;
      v1_d        = in_valid;
      sum2_d      = cs_s[ROWS-2];
      carry2_d    = cs_c[ROWS-2];
      sgn2_d      = sgn1_q;
      en2_d       = en1_q;
      clr2_d      = clr1_q;
      v2_d        = v1_q;
      out_valid_d = v2_q;
      // Bubbles leave out_data and the accumulator untouched
      if (v2_q) begin
        if (en2_q) begin
          out_data_d = acc_sum[ACC_W-1:0];
          acc_d      = acc_sum[ACC_W-1:0];
          out_ovf_d  = sgn2_q ? sgn_ovf : acc_sum[ACC_W];
        end else begin
          out_data_d = prod_ext;
          out_ovf_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sgn1_q      <= 1'b0;
      en1_q       <= 1'b0;
      clr1_q      <= 1'b0;
      v1_q        <= 1'b0;
      sum2_q      <= '0;
      carry2_q    <= '0;
      sgn2_q      <= 1'b0;
      en2_q       <= 1'b0;
      clr2_q      <= 1'b0;
      v2_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sgn1_q      <= sgn1_d;
      en1_q       <= en1_d;
      clr1_q      <= clr1_d;
      v1_q        <= v1_d;
      sum2_q      <= sum2_d;
      carry2_q    <= carry2_d;
      sgn2_q      <= sgn2_d;
      en2_q       <= en2_d;
      clr2_q      <= clr2_d;
      v2_q        <= v2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_booth_r4_pipe_mac.sv
// Self-checking bench for booth_r4_pipe_mac (N=16, ACC_W=40) with an in-order scoreboard.
module tb_booth_r4_pipe_mac;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic        in_acc_en;
  logic        in_acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        out_ovf;

  booth_r4_pipe_mac #(.N(16), .ACC_W(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_acc_en  (in_acc_en),
    .in_acc_clr (in_acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] d;
    logic        o;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_e;
  logic [39:0] m_acc;
  longint      m_x, m_y, m_p, m_tot;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  int          ovf_cnt = 0;
  int          ovf_idx = 0;
  logic [39:0] ovf_dat;

  // Scoreboard: push the reference result on each accepted beat, pop on each delivered result.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (out_ovf) begin
          ovf_cnt++;
          ovf_idx = n_out;
          ovf_dat = out_data;
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_empty: got result 0x%h, required no result", out_data);
        end else begin
          sb_e = sb.pop_front();
          if (out_data !== sb_e.d || out_ovf !== sb_e.o) begin
            n_bad++;
            $display("FAIL sb_data: got 0x%h ovf %0b, required 0x%h ovf %0b",
                     out_data, out_ovf, sb_e.d, sb_e.o);
          end
        end
      end
      if (in_valid && in_ready) begin
        m_x = in_signed ? longint'($signed(in_a)) : longint'({48'b0, in_a});
        m_y = in_signed ? longint'($signed(in_b)) : longint'({48'b0, in_b});
        m_p = m_x * m_y;
        if (!in_acc_en) begin
          sb_e.d = m_p[39:0];
          sb_e.o = 1'b0;
        end else begin
          if (in_signed) begin
            m_tot  = (in_acc_clr ? 64'sd0 : longint'($signed(m_acc))) + m_p;
            sb_e.o = (m_tot > 64'sd549755813887) || (m_tot < -64'sd549755813888);
          end else begin
            m_tot  = (in_acc_clr ? 64'sd0 : longint'({24'b0, m_acc})) + m_p;
            sb_e.o = (m_tot > 64'sd1099511627775);
          end
          sb_e.d = m_tot[39:0];
          m_acc  = m_tot[39:0];
        end
        sb.push_back(sb_e);
      end
    end
  end

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic en, input logic clr);
    int guard;
    in_a       = a;
    in_b       = b;
    in_signed  = s;
    in_acc_en  = en;
    in_acc_clr = clr;
    in_valid   = 1'b1;
    guard      = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drive_timeout: in_ready %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    n_cmp++;
    if (out_data !== 40'h0) begin n_bad++; $display("FAIL reset_out_data: got 0x%h, required 0x0", out_data); end
    n_cmp++;
    if (out_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_out_ovf: got %0b, required 0", out_ovf); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Single beats, each checked for 3-cycle latency and against a fixed expected value
  task automatic test_signed_corners();
    logic [15:0] ta [3] = '{16'h8000, 16'h8000, 16'hFFFF};
    logic [15:0] tb [3] = '{16'h8000, 16'h7FFF, 16'h0001};
    logic [39:0] te [3] = '{40'h0040000000, 40'hFFC0008000, 40'hFFFFFFFFFF};
    int lat;
    for (int i = 0; i < 3; i++) begin
      drive_beat(ta[i], tb[i], 1'b1, 1'b0, 1'b0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (lat !== 3) begin n_bad++; $display("FAIL signed_latency[%0d]: got %0d cycles, required 3", i, lat); end
      n_cmp++;
      if (out_data !== te[i]) begin n_bad++; $display("FAIL signed_corner[%0d]: got 0x%h, required 0x%h", i, out_data, te[i]); end
    end
    wait_drain();
  endtask

  task automatic test_unsigned();
    logic [15:0] ta [2] = '{16'hFFFF, 16'h8000};
    logic [15:0] tb [2] = '{16'hFFFF, 16'h0002};
    logic [39:0] te [2] = '{40'h00FFFE0001, 40'h0000010000};
    int lat;
    for (int i = 0; i < 2; i++) begin
      drive_beat(ta[i], tb[i], 1'b0, 1'b0, 1'b0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (out_data !== te[i]) begin n_bad++; $display("FAIL unsigned[%0d]: got 0x%h, required 0x%h", i, out_data, te[i]); end
    end
    wait_drain();
  endtask

  // Last beat (0*0 accumulate) shows the accumulator still holds 28 after the acc_en=0 beat
  task automatic test_accumulate();
    logic [15:0] ta [5] = '{16'd3, 16'd5, 16'hFFF9, 16'd9, 16'd0};
    logic [15:0] tb [5] = '{16'd4, 16'd6, 16'd2, 16'd9, 16'd0};
    logic        ten [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        tcl [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [39:0] te [5] = '{40'd12, 40'd42, 40'd28, 40'd81, 40'd28};
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive_beat(ta[i], tb[i], 1'b1, ten[i], tcl[i]);
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (out_data !== te[i] || out_ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL accumulate[%0d]: got 0x%h ovf %0b, required 0x%h ovf 0", i, out_data, out_ovf, te[i]);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int          out0;
    logic [39:0] hold_d;
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive_beat(16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 3 != 0), 1'(i == 1));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (c == 0) hold_d = out_data;
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== hold_d) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: got valid %0b data 0x%h, required valid 1 data 0x%h", c, out_valid, out_data, hold_d);
          end
          n_cmp++;
          if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d]: got %0b, required 0", c, in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    n_cmp++;
    if (n_out - out0 !== 8) begin n_bad++; $display("FAIL stream_count: got %0d results, required 8", n_out - out0); end
  endtask

  // 0x7FFF^2 = 1073676289; a 40-bit signed sum first passes 2^39-1 on beat 513
  task automatic test_overflow();
    int          out0, ovf0;
    longint      wrap;
    logic [39:0] exp_wrap;
    out0 = n_out;
    ovf0 = ovf_cnt;
    drive_beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 520; i++) drive_beat(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    wait_drain();
    wrap     = 64'sd513 * 64'sd1073676289;
    exp_wrap = wrap[39:0];
    n_cmp++;
    if (ovf_cnt - ovf0 !== 1) begin n_bad++; $display("FAIL ovf_count: got %0d, required 1", ovf_cnt - ovf0); end
    n_cmp++;
    if (ovf_idx - out0 !== 513) begin n_bad++; $display("FAIL ovf_beat: got beat %0d, required 513", ovf_idx - out0); end
    n_cmp++;
    if (ovf_dat !== exp_wrap) begin n_bad++; $display("FAIL ovf_wrap_data: got 0x%h, required 0x%h", ovf_dat, exp_wrap); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    drive_beat(16'd11, 16'd12, 1'b1, 1'b0, 1'b0);
    drive_beat(16'd13, 16'd14, 1'b1, 1'b1, 1'b1);
    drive_beat(16'd15, 16'd16, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 40'h0 || out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got valid %0b data 0x%h ovf %0b, required 0 0x0 0", out_valid, out_data, out_ovf);
    end
    sb.delete();
    m_acc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_beat(16'd2, 16'd3, 1'b1, 1'b1, 1'b1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (out_data !== 40'd6 || lat !== 3) begin
      n_bad++;
      $display("FAIL post_reset_beat: got 0x%h after %0d cycles, required 0x6 after 3", out_data, lat);
    end
    wait_drain();
  endtask

  task automatic test_random();
    logic [15:0] corner [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [15:0] ra, rb;
    bit          done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
          rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
          drive_beat(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_signed  = 1'b0;
    in_acc_en  = 1'b0;
    in_acc_clr = 1'b0;
    out_ready  = 1'b1;
    m_acc      = '0;
    ovf_dat    = '0;
    test_reset();
    test_signed_corners();
    test_unsigned();
    test_accumulate();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    test_random();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL final_drain: %0d results pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
